phoneme_sequencer: RTL and testbench
====================================

PHONEME_SEQUENCER -- requirements
Module: phoneme_sequencer

Interface
REQ-001 Parameter LIST_AW, default 8, SHALL set the phoneme-list address width.
REQ-002 Parameter END_CODE, default 6'h3F, SHALL be the end-of-sentence phoneme code.
REQ-003 clk_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to play the sentence at list_base.
REQ-006 abort  in  1  level; stops playback immediately.
REQ-007 list_base  in  LIST_AW  first list entry of the sentence.
REQ-008 list_addr  out  LIST_AW  phoneme-list ROM address.
REQ-009 list_data  in  6  phoneme code; valid 1 cycle after list_addr changes.
REQ-010 tbl_index  out  6  address-table ROM index, equal to the current phoneme code.
REQ-011 tbl_start, tbl_end  in  24 each  byte addresses; valid 1 cycle after tbl_index changes.
REQ-012 start_address, end_address  out  24 each  registered byte range of the current phoneme, fed to the playback FSM.
REQ-013 new_phoneme  out  1  level request to the playback FSM; drives its rst_adr input.
REQ-014 last_addr  in  2  {phoneme_rec, terminal_addr} from the playback FSM.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when a sentence completes normally.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, CHECK, LOOKUP, LOAD, WAIT_ACK, PLAY and FINISH.
REQ-018 Transition IDLE->FETCH: in IDLE, start=1 SHALL load list_addr<=list_base.
REQ-019 FETCH SHALL wait one cycle for ROM latency, then go to CHECK.
REQ-020 CHECK, list_data==END_CODE: go to FINISH.
REQ-021 CHECK, otherwise: latch list_data into tbl_index and go to LOOKUP.
REQ-022 LOOKUP SHALL wait one cycle, then go to LOAD.
REQ-023 LOAD SHALL register tbl_start/tbl_end into start_address/end_address, set new_phoneme=1, and go to WAIT_ACK.
REQ-024 WAIT_ACK SHALL hold new_phoneme=1 until last_addr[1]=1, then clear new_phoneme and go to PLAY.
REQ-025 WAIT_ACK SHALL ignore last_addr[0], which can be stale from the previous phoneme.
REQ-026 PLAY SHALL wait for last_addr[0]=1, independent of last_addr[1], so a zero-length phoneme completes correctly.
REQ-027 PLAY exit, list_addr not at its maximum (2^LIST_AW-1): increment list_addr and go to FETCH.
REQ-028 PLAY exit, list_addr at its maximum: go to FINISH with no wrap-around.
REQ-029 FINISH SHALL pulse done for exactly one cycle, then go to IDLE.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 abort=1 in any non-IDLE state SHALL, on the next edge, force IDLE and new_phoneme=0, with no done pulse.
REQ-032 abort SHALL take priority over every other transition, including a simultaneous start.
REQ-033 start_address/end_address SHALL hold their values until the next LOAD.
REQ-034 A sentence whose first code is END_CODE SHALL produce done with no new_phoneme assertion.
REQ-035 Latency SHALL be start to new_phoneme rising = 4 cycles (IDLE->FETCH->CHECK->LOOKUP->LOAD).

Reset
REQ-036 Asserting reset_n=0 SHALL immediately force: state=IDLE; list_addr=0; tbl_index=0; start_address=0; end_address=0; new_phoneme=0; busy=0; done=0.
REQ-037 Reset mid-sentence SHALL leave no pending request; the first start after release SHALL begin a fresh sentence.

Verification
REQ-038 List {05,12,3F} at base 0x10; ROM 05->(0x100,0x1FF), 12->(0x400,0x4FF); FSM model acks 2 cycles after request and terminates after 20 cycles -> two new_phoneme pulses with the correct ranges, list_addr steps 0x10->0x11->0x12, then one done.
REQ-039 First entry 3F -> done 3 cycles after start; new_phoneme never rises.
REQ-040 Stale terminal_addr=1 held through WAIT_ACK, with phoneme_rec arriving 5 cycles later -> no early advance; PLAY ends only on terminal after the ack.
REQ-041 Zero-length phoneme (phoneme_rec and terminal_addr both 1 together) -> sequencer advances to the next entry without hanging.
REQ-042 abort asserted in PLAY; separately, reset_n pulsed in WAIT_ACK -> next-cycle IDLE, new_phoneme=0, no done pulse, all outputs at reset values.
REQ-043 Base 0xFF with no END_CODE -> one phoneme plays, then done; list_addr stays 0xFF with no wrap.

Source files
------------

// File: rtl/phoneme_sequencer.sv
// Walks a phoneme list in ROM, looks up each phoneme's byte range and hands it
// to the playback FSM, advancing on its terminal-address report.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start
// FETCH    | list ROM read in flight for list_addr
// CHECK    | list_data valid; end code or latch phoneme into tbl_index
// LOOKUP   | address-table ROM read in flight
// LOAD     | new_phoneme raised; capture tbl_start/tbl_end this cycle
// WAIT_ACK | holding new_phoneme until playback reports phoneme_rec
// PLAY     | waiting for playback terminal_addr
// FINISH   | one-cycle done pulse
module phoneme_sequencer #(
    parameter int          LIST_AW  = 8,
    parameter logic [5:0]  END_CODE = 6'h3F
) (
    input  logic               clk_50,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [LIST_AW-1:0] list_base,
    output logic [LIST_AW-1:0] list_addr,
    input  logic [5:0]         list_data,
    output logic [5:0]         tbl_index,
    input  logic [23:0]        tbl_start,
    input  logic [23:0]        tbl_end,
    output logic [23:0]        start_address,
    output logic [23:0]        end_address,
    output logic               new_phoneme,
    input  logic [1:0]         last_addr,
    output logic               busy,
    output logic               done
);

    localparam logic [LIST_AW-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        LOOKUP,
        LOAD,
        WAIT_ACK,
        PLAY,
        FINISH
    } state_t;

    state_t state, state_nxt;

    logic ld_base;
    logic inc_addr;
    logic ld_idx;
    logic ld_rng;
    logic set_np;
    logic clr_np;

    wire phoneme_rec   = last_addr[1];
    wire terminal_addr = last_addr[0];

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_base   = 1'b0;
        inc_addr  = 1'b0;
        ld_idx    = 1'b0;
        ld_rng    = 1'b0;
        set_np    = 1'b0;
        clr_np    = 1'b0;
        // abort wins over everything, and also blocks a start arriving with it
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            clr_np    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        ld_base   = 1'b1;
                        state_nxt = FETCH;
                    end
                end
                FETCH: state_nxt = CHECK;
                CHECK: begin
                    if (list_data == END_CODE) begin
                        state_nxt = FINISH;
                    end else begin
                        ld_idx    = 1'b1;
                        state_nxt = LOOKUP;
                    end
                end
                LOOKUP: begin
                    set_np    = 1'b1;
                    state_nxt = LOAD;
                end
                LOAD: begin
                    ld_rng    = 1'b1;
                    state_nxt = WAIT_ACK;
                end
                // terminal_addr may still be high from the previous phoneme here
                WAIT_ACK: begin
                    if (phoneme_rec) begin
                        clr_np    = 1'b1;
                        state_nxt = PLAY;
                    end
                end
                PLAY: begin
                    if (terminal_addr) begin
                        if (list_addr == ADDR_MAX) begin
                            state_nxt = FINISH;
                        end else begin
                            inc_addr  = 1'b1;
                            state_nxt = FETCH;
                        end
                    end
                end
                FINISH:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            list_addr     <= '0;
            tbl_index     <= '0;
            start_address <= '0;
            end_address   <= '0;
            new_phoneme   <= 1'b0;
        end else begin
            if (ld_base) begin
                list_addr <= list_base;
            end else if (inc_addr) begin
                list_addr <= list_addr + LIST_AW'(1);
            end
            if (ld_idx) begin
                tbl_index <= list_data;
            end
            if (ld_rng) begin
                start_address <= tbl_start;
                end_address   <= tbl_end;
            end
            if (clr_np) begin
                new_phoneme <= 1'b0;
            end else if (set_np) begin
                new_phoneme <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

endmodule

// File: tb/tb_phoneme_sequencer.sv
// Scoreboarded bench for phoneme_sequencer: list/table ROM models, a small
// playback-FSM model, and a monitor that pops expected loads and done pulses.
module tb_phoneme_sequencer;

    localparam logic [5:0] END_C = 6'h3F;

    logic        clk_50;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [7:0]  list_base;
    logic [7:0]  list_addr;
    logic [5:0]  list_data;
    logic [5:0]  tbl_index;
    logic [23:0] tbl_start;
    logic [23:0] tbl_end;
    logic [23:0] start_address;
    logic [23:0] end_address;
    logic        new_phoneme;
    logic [1:0]  last_addr;
    logic        busy;
    logic        done;

    phoneme_sequencer #(.LIST_AW(8), .END_CODE(END_C)) dut (
        .clk_50        (clk_50),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .list_base     (list_base),
        .list_addr     (list_addr),
        .list_data     (list_data),
        .tbl_index     (tbl_index),
        .tbl_start     (tbl_start),
        .tbl_end       (tbl_end),
        .start_address (start_address),
        .end_address   (end_address),
        .new_phoneme   (new_phoneme),
        .last_addr     (last_addr),
        .busy          (busy),
        .done          (done)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // ROM models: one-cycle registered read
    logic [5:0]  list_rom [256];
    logic [23:0] tbl_s [64];
    logic [23:0] tbl_e [64];

    always @(posedge clk_50) begin
        list_data <= list_rom[list_addr];
        tbl_start <= tbl_s[tbl_index];
        tbl_end   <= tbl_e[tbl_index];
    end

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    // playback FSM model: phoneme_rec pulse m_ack cycles after request,
    // terminal_addr (sticky level) m_term cycles after that
    int   m_ack   = 2;
    int   m_term  = 20;
    bit   m_stale = 1'b0;
    int   m_cnt   = 0;
    bit   m_active = 1'b0;
    bit   m_np_prev = 1'b0;
    bit   m_hit;

    initial last_addr = 2'b00;

    always @(negedge clk_50) begin
        if (!reset_n || !busy) begin
            m_active  = 1'b0;
            last_addr = 2'b00;
        end else begin
            m_hit = 1'b0;
            if (new_phoneme && !m_np_prev) begin
                m_active     = 1'b1;
                m_cnt        = 0;
                last_addr[0] = m_stale;
            end else if (m_active) begin
                m_cnt++;
            end
            if (m_active && m_cnt == m_ack) begin
                m_hit        = 1'b1;
                last_addr[0] = (m_term == 0);
                if (m_term == 0) m_active = 1'b0;
            end else if (m_active && m_cnt > m_ack && m_cnt >= m_ack + m_term) begin
                last_addr[0] = 1'b1;
                m_active     = 1'b0;
            end
            last_addr[1] = m_hit;
        end
        m_np_prev = new_phoneme;
    end

    typedef struct {
        int          kind;   // 0 = phoneme load, 1 = done
        logic [7:0]  addr;
        logic [5:0]  code;
        logic [23:0] s;
        logic [23:0] e;
        int          lat;
    } ev_t;

    ev_t sb[$];
    int  start_cyc = 0;

    // Expected events for a sentence; lat is in cycles after the start cycle.
    task automatic push_sentence(input logic [7:0] base, input int a, input int t, input bit first_only);
        logic [7:0] ptr;
        logic [5:0] code;
        int         fe;
        int         span;
        ev_t        ev;
        ptr  = base;
        fe   = 1;
        span = (a + t > a + 1) ? a + t : a + 1;
        for (int n = 0; n < 256; n++) begin
            code = list_rom[ptr];
            if (code == END_C) begin
                ev = '{kind: 1, addr: ptr, code: 6'd0, s: 24'd0, e: 24'd0, lat: fe + 2};
                sb.push_back(ev);
                break;
            end
            ev = '{kind: 0, addr: ptr, code: code, s: tbl_s[code], e: tbl_e[code], lat: fe + 3};
            sb.push_back(ev);
            if (first_only) break;
            fe = fe + 3 + span + 1;
            if (ptr == 8'hFF) begin
                ev = '{kind: 1, addr: ptr, code: 6'd0, s: 24'd0, e: 24'd0, lat: fe};
                sb.push_back(ev);
                break;
            end
            ptr = ptr + 8'd1;
        end
    endtask

    // monitor
    bit          np_prev   = 1'b0;
    bit          done_prev = 1'b0;
    bit          rng_pend  = 1'b0;
    logic [23:0] pend_s, pend_e;
    ev_t         got;

    always @(negedge clk_50) begin
        if (reset_n) begin
            if (rng_pend) begin
                chk("start_address", 32'(start_address), 32'(pend_s));
                chk("end_address", 32'(end_address), 32'(pend_e));
                rng_pend = 1'b0;
            end
            if (done_prev) chk("done_width", 32'(done), 32'd0);
            if (new_phoneme && !np_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_phoneme", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("event_kind_ph", 32'd0, 32'(got.kind));
                    chk("ph_list_addr", 32'(list_addr), 32'(got.addr));
                    chk("tbl_index", 32'(tbl_index), 32'(got.code));
                    chk("ph_latency", 32'(cyc - start_cyc), 32'(got.lat));
                    pend_s   = got.s;
                    pend_e   = got.e;
                    rng_pend = 1'b1;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("event_kind_done", 32'd1, 32'(got.kind));
                    chk("done_list_addr", 32'(list_addr), 32'(got.addr));
                    chk("done_latency", 32'(cyc - start_cyc), 32'(got.lat));
                end
            end
        end else begin
            rng_pend = 1'b0;
        end
        np_prev   = new_phoneme;
        done_prev = done && reset_n;
    end

    task automatic start_seq(input logic [7:0] base);
        @(negedge clk_50);
        list_base = base;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk_50);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk_50);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        if (busy) begin
            abort = 1'b1;
            @(negedge clk_50);
            abort = 1'b0;
        end
        repeat (2) @(negedge clk_50);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_list_addr"}, 32'(list_addr), 32'd0);
        chk({tag, "_tbl_index"}, 32'(tbl_index), 32'd0);
        chk({tag, "_start_address"}, 32'(start_address), 32'd0);
        chk({tag, "_end_address"}, 32'(end_address), 32'd0);
        chk({tag, "_new_phoneme"}, 32'(new_phoneme), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        repeat (20000) @(posedge clk_50);
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) list_rom[i] = END_C;
        for (int c = 0; c < 64; c++) begin
            tbl_s[c] = {c[5:0], 18'h00007};
            tbl_e[c] = {c[5:0], 18'h3FFF0};
        end
        tbl_s[6'h05] = 24'h000100;  tbl_e[6'h05] = 24'h0001FF;
        tbl_s[6'h12] = 24'h000400;  tbl_e[6'h12] = 24'h0004FF;
        list_rom[8'h10] = 6'h05; list_rom[8'h11] = 6'h12; list_rom[8'h12] = END_C;
        list_rom[8'h20] = 6'h12; list_rom[8'h21] = END_C;
        list_rom[8'h30] = 6'h05; list_rom[8'h31] = 6'h12; list_rom[8'h32] = END_C;
        list_rom[8'h40] = END_C;
        list_rom[8'hFF] = 6'h05;

        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        list_base = 8'h00;
        repeat (3) @(negedge clk_50);
        chk_reset_outputs("por");
        reset_n = 1'b1;
        repeat (2) @(negedge clk_50);

        // two-phoneme sentence; a second start mid-sentence must be ignored
        m_ack = 2; m_term = 20; m_stale = 1'b0;
        push_sentence(8'h10, m_ack, m_term, 1'b0);
        start_seq(8'h10);
        while (cyc < start_cyc + 10) @(negedge clk_50);
        list_base = 8'h30;
        start     = 1'b1;
        @(negedge clk_50);
        start     = 1'b0;
        wait_idle(200);

        // first entry is the end code
        push_sentence(8'h40, m_ack, m_term, 1'b0);
        start_seq(8'h40);
        wait_idle(50);

        // stale terminal_addr through WAIT_ACK, late phoneme_rec
        m_ack = 5; m_term = 4; m_stale = 1'b1;
        push_sentence(8'h20, m_ack, m_term, 1'b0);
        start_seq(8'h20);
        wait_idle(100);

        // zero-length phonemes
        m_ack = 2; m_term = 0; m_stale = 1'b0;
        push_sentence(8'h30, m_ack, m_term, 1'b0);
        start_seq(8'h30);
        wait_idle(100);

        // last list address, no end code: no wrap
        m_ack = 2; m_term = 3;
        push_sentence(8'hFF, m_ack, m_term, 1'b0);
        start_seq(8'hFF);
        wait_idle(100);

        // abort during PLAY
        m_ack = 2; m_term = 20;
        push_sentence(8'h10, m_ack, m_term, 1'b1);
        start_seq(8'h10);
        while (cyc < start_cyc + 10) @(negedge clk_50);
        abort = 1'b1;
        @(negedge clk_50);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_new_phoneme", 32'(new_phoneme), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        abort = 1'b0;
        repeat (30) @(negedge clk_50);
        chk("abort_stays_idle", 32'(busy), 32'd0);

        // abort together with start in IDLE
        @(negedge clk_50);
        abort     = 1'b1;
        start     = 1'b1;
        list_base = 8'h20;
        @(negedge clk_50);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        @(negedge clk_50);
        chk("abort_start_busy2", 32'(busy), 32'd0);

        // reset pulse in WAIT_ACK, then a fresh sentence
        push_sentence(8'h10, m_ack, m_term, 1'b1);
        start_seq(8'h10);
        while (cyc < start_cyc + 6) @(negedge clk_50);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("rst_wait_ack");
        @(negedge clk_50);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_50);
        chk("post_reset_idle", 32'(busy), 32'd0);

        m_ack = 2; m_term = 0;
        push_sentence(8'h30, m_ack, m_term, 1'b0);
        start_seq(8'h30);
        wait_idle(100);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
